// File: rtl/seg_pkg.sv
// Shared constants for the two-digit seven-segment scanner.
// Segment/anode values are active-low; bytes are ordered dp,g,f,e,d,c,b,a.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK     = 7'h7F;
  localparam logic [3:0] AN_OFF        = 4'b1111;
  localparam logic [3:0] AN_ONES       = 4'b1110;
  localparam logic [3:0] AN_TENS       = 4'b1101;
  localparam logic [7:0] SEG_ZERO_BYTE = 8'hC0;

  localparam int AN_IDX_ONES = 0;
  localparam int AN_IDX_TENS = 1;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } digit_e;

endpackage

// File: rtl/seven_segment_scan_timer.sv
// Slot timer: free-running slot counter, end-of-slot tick and start-of-slot gap flag.
module seg_slot_timer #(
  parameter int DIV_WIDTH  = 17,
  parameter int GAP_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o,
  output logic in_gap_o
);

  localparam logic [DIV_WIDTH-1:0] GAP = DIV_WIDTH'(GAP_CYCLES);

  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + 1'b1;
  end

  assign tick_o   = &cnt_q;
  assign in_gap_o = (cnt_q < GAP);

endmodule

// File: rtl/seven_segment_scan.sv
// Two-digit multiplexed driver for a common-anode display, frame-latched input.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks a '0' tens digit.
module seven_segment_scan
  import seg_pkg::*;
#(
  parameter int DIV_WIDTH  = 17,
  parameter int GAP_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] display,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  logic        tick, in_gap;
  digit_e      sel_q, sel_d;
  logic        started_q, started_d;
  logic [15:0] shadow_q, shadow_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;
  logic        blank;
  logic [7:0]  digit_byte;

  seg_slot_timer #(
    .DIV_WIDTH (DIV_WIDTH),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_o  (tick),
    .in_gap_o(in_gap)
  );

  always_comb begin
    sel_d     = sel_q;
    started_d = started_q;
    shadow_d  = shadow_q;
    if (tick) begin
      sel_d     = (sel_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
      started_d = 1'b1;
      // leaving the tens slot starts a new frame: latch the whole word at once
      if (sel_q == DIG_TENS) shadow_d = display;
    end

    digit_byte = (sel_q == DIG_ONES) ? shadow_q[7:0] : shadow_q[15:8];
    blank      = in_gap || !started_q;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (sel_q == DIG_TENS && shadow_q[15:8] == SEG_ZERO_BYTE) blank = 1'b1;
`endif

    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d         = (sel_q == DIG_ONES) ? AN_ONES : AN_TENS;
      {dp_d, seg_d} = digit_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= DIG_TENS;
      started_q <= 1'b0;
      shadow_q  <= 16'hFFFF;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      sel_q     <= sel_d;
      started_q <= started_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
